// File: rtl/rv_pkg.sv
// Shared definitions for the write-back stage: result-source encoding,
// load funct3 codes and the bus-wait FSM state type.
package rv_pkg;

    localparam logic [1:0] RESULT_SRC_ALU   = 2'd0;
    localparam logic [1:0] RESULT_SRC_MEM   = 2'd1;
    localparam logic [1:0] RESULT_SRC_PC_P4 = 2'd2;
    localparam logic [1:0] RESULT_SRC_TCM   = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/rv_write_back_if.sv
// Data-bus read-return channel into the write-back stage.
interface rv_write_back_if;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    // Bus side drives the read return
    modport master (output bus_rdata, output bus_ack);
    // Write-back stage consumes it
    modport slave  (input  bus_rdata, input  bus_ack);
endinterface

// File: rtl/rv_load_align.sv
// Byte/half lane selection and sign/zero extension of load data.
module rv_load_align
    import rv_pkg::*;
(
    input  logic [31:0] i_data,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    output logic [31:0] o_value
);

    function automatic logic [31:0] sext8(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] h);
        return {{16{h[15]}}, h};
    endfunction

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and half-word lanes
    always_comb begin
        w_byte = i_data[7:0];
        case (i_addr)
            2'd0: w_byte = i_data[7:0];
            2'd1: w_byte = i_data[15:8];
            2'd2: w_byte = i_data[23:16];
            2'd3: w_byte = i_data[31:24];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_addr[1] ? i_data[31:16] : i_data[15:0];
    end

    // Extend according to load width/sign; unknown codes pass the full word
    always_comb begin
        o_value = i_data;
        case (i_funct3)
            F3_LB:   o_value = sext8(w_byte);
            F3_LH:   o_value = sext16(w_half);
            F3_LBU:  o_value = {24'd0, w_byte};
            F3_LHU:  o_value = {16'd0, w_half};
            default: o_value = i_data;
        endcase
    end

endmodule

// File: rtl/rv_write_back.sv
// Write-back stage: registers the memory-stage outputs, stalls while a
// data-bus load waits for its ack (with timeout fault), aligns load data
// and drives the register-file write port.
module rv_write_back
    import rv_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_alu_result,
    input  logic        i_reg_write,
    input  logic        i_mem_read,
    input  logic [4:0]  i_rd,
    input  logic [1:0]  i_res_src,
    input  logic [2:0]  i_funct3,
    input  logic [29:0] i_pc_p4,
    input  logic [31:0] i_tcm_rdata,
    rv_write_back_if.slave bus,
    output logic        o_stall,
    output logic        o_reg_write,
    output logic [4:0]  o_rd,
    output logic [31:0] o_result,
    output logic        o_bus_fault
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic        r_vld_p0;
    logic [31:0] r_alu_p0;
    logic        r_reg_write_p0;
    logic        r_mem_read_p0;
    logic [4:0]  r_rd_p0;
    logic [1:0]  r_res_src_p0;
    logic [2:0]  r_funct3_p0;
    logic [29:0] r_pc_p4_p0;

    wb_state_t   r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic        w_stall, w_fault;
    logic        w_active, w_bus_load;
    logic [31:0] w_ld_data, w_ld_value;

    assign w_active   = r_vld_p0 & ~i_reset;
    assign w_bus_load = w_active & r_mem_read_p0 & (r_res_src_p0 == RESULT_SRC_MEM);

    // Stage valid: the only stage field that needs a reset value
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_vld_p0 <= 1'b0;
        else if (!w_stall)
            r_vld_p0 <= 1'b1;
    end

    // Memory-stage -> write-back boundary; held while stalled
    always_ff @(posedge i_clk) begin
        if (!w_stall) begin
            r_alu_p0       <= i_alu_result;
            r_reg_write_p0 <= i_reg_write;
            r_mem_read_p0  <= i_mem_read;
            r_rd_p0        <= i_rd;
            r_res_src_p0   <= i_res_src;
            r_funct3_p0    <= i_funct3;
            r_pc_p4_p0     <= i_pc_p4;
        end
    end

    // Bus-wait FSM state and timeout counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= WB_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state, stall and fault; an ack always beats the timeout
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            WB_IDLE: begin
                if (w_bus_load && !bus.bus_ack) begin
                    w_stall     = 1'b1;
                    w_state_nxt = WB_WAIT;
                    w_cnt_nxt   = 8'd1;
                end
            end
            WB_WAIT: begin
                if (!w_bus_load || bus.bus_ack) begin
                    w_state_nxt = WB_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else if (r_cnt == CNT_LAST) begin
                    w_fault     = 1'b1;
                    w_state_nxt = WB_IDLE;
                    w_cnt_nxt   = 8'd0;
                end else begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = WB_IDLE;
                w_cnt_nxt   = 8'd0;
            end
        endcase
    end

    assign w_ld_data = (r_res_src_p0 == RESULT_SRC_TCM) ? i_tcm_rdata : bus.bus_rdata;

    rv_load_align u_align (
        .i_data   (w_ld_data),
        .i_funct3 (r_funct3_p0),
        .i_addr   (r_alu_p0[1:0]),
        .o_value  (w_ld_value)
    );

    // Result mux and register-file write port
    always_comb begin
        o_result = 32'd0;
        if (w_active) begin
            case (r_res_src_p0)
                RESULT_SRC_ALU:   o_result = r_alu_p0;
                RESULT_SRC_PC_P4: o_result = {r_pc_p4_p0, 2'b00};
                default:          o_result = w_ld_value;
            endcase
        end
        o_rd        = w_active ? r_rd_p0 : 5'd0;
        o_reg_write = w_active & r_reg_write_p0 & (~w_bus_load | bus.bus_ack) & ~w_fault;
        o_stall     = w_stall;
        o_bus_fault = w_fault;
    end

endmodule
